// File: rtl/stdp_timing_tracker.sv
// Tracks the ages of the most recent pre- and postsynaptic spikes and emits a
// signed Q-format pairing interval (t_post - t_pre) for each qualifying spike pair.
module stdp_timing_tracker #(
   parameter int N      = 32,
   parameter int Q      = 16,
   parameter int CNT_W  = 12,
   parameter int WINDOW = 1000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         pre_spike,
   input  logic         post_spike,
   output logic         apply,
   output logic [N-1:0] t_change
);

   if ((CNT_W + Q + 1 > N) || (WINDOW > (2 ** CNT_W) - 2)) begin : g_param_check
      $error("stdp_timing_tracker: require CNT_W+Q+1 <= N and WINDOW <= 2**CNT_W-2");
   end

   localparam logic [CNT_W-1:0] AGE_MAX = '1;
   localparam logic [CNT_W-1:0] AGE_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] WIN     = CNT_W'(WINDOW);

   typedef enum logic [1:0] {
      EV_NONE = 2'b00,
      EV_POST = 2'b01,
      EV_PRE  = 2'b10,
      EV_BOTH = 2'b11
   } event_e;

   logic [CNT_W-1:0] pre_age, post_age;
   logic             pre_seen, post_seen;

   logic [CNT_W-1:0] pre_age_nxt, post_age_nxt;
   logic             pre_seen_nxt, post_seen_nxt;
   logic             pair_valid;
   logic [N-1:0]     pair_value;
   logic [N-1:0]     pre_ext, post_ext;
   event_e           ev;

   function automatic logic [CNT_W-1:0] age_step(input logic spike, input logic [CNT_W-1:0] age);
      if (spike)
         return AGE_ONE;
      else if (age == AGE_MAX)
         return age;
      else
         return age + AGE_ONE;
   endfunction

   assign pre_ext  = {{(N-CNT_W){1'b0}}, pre_age};
   assign post_ext = {{(N-CNT_W){1'b0}}, post_age};
   assign ev       = event_e'({pre_spike, post_spike});

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      pair_valid    = 1'b0;
      pair_value    = '0;
      pre_seen_nxt  = pre_seen;
      post_seen_nxt = post_seen;
      pre_age_nxt   = pre_age;
      post_age_nxt  = post_age;

      if (enable) begin
         pre_age_nxt  = age_step(pre_spike, pre_age);
         post_age_nxt = age_step(post_spike, post_age);

         unique case (ev)
            EV_BOTH: begin
               // Coincident spikes pair with each other and consume both partners.
               pair_valid    = 1'b1;
               pair_value    = '0;
               pre_seen_nxt  = 1'b0;
               post_seen_nxt = 1'b0;
            end
            EV_POST: begin
               if (pre_seen && (pre_age <= WIN)) begin
                  pair_valid = 1'b1;
                  pair_value = pre_ext << Q;
               end
               pre_seen_nxt  = 1'b0;
               post_seen_nxt = 1'b1;
            end
            EV_PRE: begin
               if (post_seen && (post_age <= WIN)) begin
                  pair_valid = 1'b1;
                  pair_value = -(post_ext << Q);
               end
               post_seen_nxt = 1'b0;
               pre_seen_nxt  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_age   <= AGE_MAX;
         post_age  <= AGE_MAX;
         pre_seen  <= 1'b0;
         post_seen <= 1'b0;
         apply     <= 1'b0;
         t_change  <= '0;
      end else begin
         pre_age   <= pre_age_nxt;
         post_age  <= post_age_nxt;
         pre_seen  <= pre_seen_nxt;
         post_seen <= post_seen_nxt;
         apply     <= pair_valid;
         if (pair_valid)
            t_change <= pair_value;
      end
   end

endmodule

// File: tb/tb_stdp_timing_tracker.sv
// Scoreboard bench for stdp_timing_tracker: a behavioural model queues the expected
// outputs per driven edge; a monitor pops and compares them after each rising edge.
module tb_stdp_timing_tracker;

   localparam int N       = 32;
   localparam int Q       = 16;
   localparam int CNT_W   = 12;
   localparam int WINDOW  = 1000;
   localparam int AGE_MAX = 4095;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic         pre_spike = 1'b0;
   logic         post_spike = 1'b0;
   logic         apply;
   logic [N-1:0] t_change;

   typedef struct packed {
      logic         apply;
      logic [N-1:0] tchg;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int          m_pre_age = AGE_MAX;
   int          m_post_age = AGE_MAX;
   bit          m_pre_seen = 0;
   bit          m_post_seen = 0;
   logic [31:0] m_tchg = '0;

   stdp_timing_tracker #(.N(N), .Q(Q), .CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .pre_spike (pre_spike),
      .post_spike(post_spike),
      .apply     (apply),
      .t_change  (t_change)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: computes the outputs expected after the coming edge.
   task automatic model(input bit en, input bit pre, input bit post, input bit rst);
      exp_t e;
      e.apply = 1'b0;
      if (rst) begin
         m_pre_age = AGE_MAX; m_post_age = AGE_MAX;
         m_pre_seen = 0; m_post_seen = 0; m_tchg = '0;
      end else if (en) begin
         if (pre && post) begin
            e.apply = 1'b1; m_tchg = '0;
            m_pre_seen = 0; m_post_seen = 0;
         end else if (post) begin
            if (m_pre_seen && m_pre_age <= WINDOW) begin
               e.apply = 1'b1; m_tchg = 32'(m_pre_age * 65536);
            end
            m_pre_seen = 0; m_post_seen = 1;
         end else if (pre) begin
            if (m_post_seen && m_post_age <= WINDOW) begin
               e.apply = 1'b1; m_tchg = 32'(0 - m_post_age * 65536);
            end
            m_post_seen = 0; m_pre_seen = 1;
         end
         m_pre_age  = pre  ? 1 : (m_pre_age  < AGE_MAX ? m_pre_age + 1  : AGE_MAX);
         m_post_age = post ? 1 : (m_post_age < AGE_MAX ? m_post_age + 1 : AGE_MAX);
      end
      e.tchg = m_tchg;
      sb.push_back(e);
   endtask

   task automatic cyc(input bit en, input bit pre, input bit post, input bit rst = 0);
      @(negedge clk);
      enable = en; pre_spike = pre; post_spike = post; reset = rst;
      model(en, pre, post, rst);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("apply", {63'd0, apply}, {63'd0, e.apply});
            check("t_change", {32'd0, t_change}, {32'd0, e.tchg});
         end
      end
   end

   initial begin : stim
      // Reset has priority over enable and spikes.
      cyc(1, 1, 1, 1);
      check("reset_apply", {63'd0, apply}, 64'd0);
      check("reset_tchg", {32'd0, t_change}, 64'd0);

      // Post 5 edges after pre.
      cyc(1, 1, 0); idle(4); cyc(1, 0, 1);
      check("pre_post_apply", {63'd0, apply}, 64'd1);
      check("pre_post_tchg", {32'd0, t_change}, 64'h0005_0000);
      idle(1);
      check("pulse_width", {63'd0, apply}, 64'd0);
      check("tchg_hold", {32'd0, t_change}, 64'h0005_0000);

      // Pre 3 edges after post.
      cyc(1, 0, 0, 1);
      cyc(1, 0, 1); idle(2); cyc(1, 1, 0);
      check("post_pre_apply", {63'd0, apply}, 64'd1);
      check("post_pre_tchg", {32'd0, t_change}, 64'hFFFD_0000);

      // Coincident spikes, then a post that must find no partner.
      cyc(1, 0, 0, 1);
      cyc(1, 1, 0); idle(3); cyc(1, 1, 1);
      check("both_apply", {63'd0, apply}, 64'd1);
      check("both_tchg", {32'd0, t_change}, 64'd0);
      idle(1); cyc(1, 0, 1);
      check("after_both_apply", {63'd0, apply}, 64'd0);

      // Window edge: 1001 misses, 1000 pairs.
      cyc(1, 0, 0, 1);
      cyc(1, 1, 0); idle(1000); cyc(1, 0, 1);
      check("win_1001_apply", {63'd0, apply}, 64'd0);
      cyc(1, 0, 0, 1);
      cyc(1, 1, 0); idle(999); cyc(1, 0, 1);
      check("win_1000_apply", {63'd0, apply}, 64'd1);
      check("win_1000_tchg", {32'd0, t_change}, 64'h03E8_0000);

      // Saturated partner age never pairs.
      cyc(1, 0, 0, 1);
      cyc(1, 0, 1);
      check("no_partner_apply", {63'd0, apply}, 64'd0);

      // Ages freeze while disabled; spikes ignored.
      cyc(1, 0, 0, 1);
      cyc(1, 1, 0);
      for (int i = 1; i <= 10; i++) cyc(0, 0, (i % 3) == 0);
      check("disabled_apply", {63'd0, apply}, 64'd0);
      cyc(1, 0, 0); cyc(1, 0, 1);
      check("enable_apply", {63'd0, apply}, 64'd1);
      check("enable_tchg", {32'd0, t_change}, 64'h0002_0000);

      // Reset mid-pairing discards the pending pre.
      cyc(1, 1, 0); idle(1); cyc(1, 0, 0, 1);
      check("midreset_apply", {63'd0, apply}, 64'd0);
      check("midreset_tchg", {32'd0, t_change}, 64'd0);
      idle(1); cyc(1, 0, 1);
      check("midreset_post", {63'd0, apply}, 64'd0);

      // Back-to-back pairings on consecutive edges.
      cyc(1, 1, 0); cyc(1, 0, 1);
      check("b2b_first", {32'd0, t_change}, 64'h0001_0000);
      cyc(1, 1, 0);
      check("b2b_second_apply", {63'd0, apply}, 64'd1);
      check("b2b_second_tchg", {32'd0, t_change}, 64'hFFFF_0000);

      // Random traffic checked against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 11) == 0), ($urandom_range(0, 499) == 0));
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
